// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets CORES requesters share a single UART transmitter.
// It issues one start pulse per byte and flags a UART that never reports busy.
module uart_tx_arbiter #(
    parameter int CORES        = 4,
    parameter int WIDTH        = 8,
    parameter int BUSY_TIMEOUT = 15,
    localparam int GW          = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CORES-1:0]       req,
    input  logic [CORES*WIDTH-1:0] data_in,
    output logic [CORES-1:0]       ack,
    output logic                   uart_start,
    output logic [WIDTH-1:0]       uart_data_tx,
    input  logic                   uart_busy,
    output logic [GW-1:0]          grant_id,
    output logic                   timeout_err
);

    localparam int CW = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [CORES-1:0] r_ack;
    logic             r_start;
    logic [WIDTH-1:0] r_data;
    logic [GW-1:0]    r_gid;
    logic [GW-1:0]    r_last;
    logic [CW-1:0]    r_cnt;
    logic             r_timeout;

    logic             w_found;
    logic [GW-1:0]    w_gnt;
    logic [GW-1:0]    w_cand;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] w_bytes [CORES];

    always_comb begin
        for (int unsigned i = 0; i < CORES; i++) begin
            w_bytes[i] = data_in[i*WIDTH +: WIDTH];
        end
    end

    // Scan starts one past the last winner, so the first hit is the round-robin choice.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int unsigned i = 1; i <= CORES; i++) begin
            w_cand = GW'((32'(r_last) + i) % 32'(CORES));
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_cnt_next = r_cnt + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ack     <= '0;
            r_start   <= 1'b0;
            r_data    <= '0;
            r_gid     <= '0;
            r_last    <= GW'(CORES - 1);
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found && !uart_busy) begin
                        r_ack   <= CORES'(1) << w_gnt;
                        r_start <= 1'b1;
                        r_data  <= w_bytes[w_gnt];
                        r_gid   <= w_gnt;
                        r_last  <= w_gnt;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_ack   <= '0;
                    r_start <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (uart_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next >= CW'(BUSY_TIMEOUT)) begin
                            r_state   <= S_IDLE;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!uart_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack          = r_ack;
    assign uart_start   = r_start;
    assign uart_data_tx = r_data;
    assign grant_id     = r_gid;
    assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios plus a randomized run scored against a transaction-level
// round-robin predictor and a simple UART busy model.
module tb_uart_tx_arbiter;

    localparam int CORES = 4;
    localparam int WIDTH = 8;
    localparam int TMO   = 15;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [CORES-1:0]            req;
    logic [CORES-1:0][WIDTH-1:0] bytes;
    logic [CORES*WIDTH-1:0]      data_in;
    logic [CORES-1:0]            ack;
    logic                        uart_start;
    logic [WIDTH-1:0]            uart_data_tx;
    logic                        uart_busy;
    logic [1:0]                  grant_id;
    logic                        timeout_err;

    int n_total = 0;
    int n_bad   = 0;

    int u_delay = 1;
    int u_len   = 10;
    int t_rise  = 0;
    int t_fall  = 0;
    bit u_never = 1'b0;
    bit u_hold  = 1'b0;

    logic [CORES-1:0]            req_prev;
    logic [CORES-1:0][WIDTH-1:0] bytes_prev;
    logic                        busy_prev;

    assign data_in = bytes;

    uart_tx_arbiter #(
        .CORES(CORES),
        .WIDTH(WIDTH),
        .BUSY_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .data_in(data_in),
        .ack(ack),
        .uart_start(uart_start),
        .uart_data_tx(uart_data_tx),
        .uart_busy(uart_busy),
        .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [CORES-1:0] r);
        for (int i = 1; i <= CORES; i++) begin
            if (r[(last + i) % CORES]) return (last + i) % CORES;
        end
        return -1;
    endfunction

    // One clock: capture what the DUT will sample, then advance the UART model.
    task automatic tick();
        req_prev   = req;
        bytes_prev = bytes;
        busy_prev  = uart_busy;
        @(posedge clk);
        #1;
        if (!u_hold) begin
            if (t_fall > 0) begin
                t_fall--;
                if (t_fall == 0) uart_busy = 1'b0;
            end else if (t_rise > 0) begin
                t_rise--;
                if (t_rise == 0) begin
                    uart_busy = 1'b1;
                    t_fall    = u_len;
                end
            end
            if (uart_start && !u_never) t_rise = u_delay;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req       = '0;
        uart_busy = 1'b0;
        t_rise    = 0;
        t_fall    = 0;
        u_hold    = 1'b0;
        u_never   = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!uart_start && n < max);
    endtask

    task automatic drain();
        req = '0;
        repeat (20) tick();
    endtask

    initial begin
        int n;
        int cnt;
        int exp_g;
        int exp_last;
        int last_t;
        int nstart;

        bytes = '0;
        do_reset();
        check("rst_ack", ack, 0);
        check("rst_start", uart_start, 0);
        check("rst_data", uart_data_tx, 0);
        check("rst_gid", grant_id, 0);
        check("rst_tmo", timeout_err, 0);

        // single requester 2, UART busy one cycle after start for 10 cycles
        u_delay  = 1;
        u_len    = 10;
        bytes[2] = 8'h41;
        req      = 4'b0100;
        tick();
        check("t1_ack", ack, 4'b0100);
        check("t1_start", uart_start, 1);
        check("t1_data", uart_data_tx, 8'h41);
        check("t1_gid", grant_id, 2);
        req      = '0;
        bytes[2] = 8'h42;
        tick();
        check("t1_ack_clr", ack, 0);
        check("t1_start_clr", uart_start, 0);
        check("t1_data_hold", uart_data_tx, 8'h41);
        req = 4'b0100;
        wait_start(40, n);
        check("t1_spacing", n, 12);
        check("t1_data2", uart_data_tx, 8'h42);
        drain();

        // all four held: round-robin order from a fresh reset
        do_reset();
        u_len = 3;
        for (int i = 0; i < CORES; i++) bytes[i] = 8'(8'h30 + i);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_start(40, n);
            check("t2_spacing", n, (k == 0) ? 1 : 6);
            check("t2_gid", grant_id, k % 4);
            check("t2_data", uart_data_tx, 8'h30 + (k % 4));
            check("t2_ack", ack, 1 << (k % 4));
        end
        drain();

        // busy held high while idle blocks any grant
        u_hold    = 1'b1;
        uart_busy = 1'b1;
        req       = 4'b0010;
        cnt       = 0;
        repeat (5) begin
            tick();
            if (uart_start || ack != 0) cnt++;
        end
        check("t3_blocked", cnt, 0);
        uart_busy = 1'b0;
        u_hold    = 1'b0;
        tick();
        check("t3_start", uart_start, 1);
        check("t3_gid", grant_id, 1);
        check("t3_ack", ack, 4'b0010);
        drain();

        // UART never goes busy: timeout after 15 waiting cycles, flag is sticky
        u_never = 1'b1;
        u_len   = 3;
        req     = 4'b0001;
        wait_start(40, n);
        check("t4_start", uart_start, 1);
        repeat (15) tick();
        check("t4_tmo_pre", timeout_err, 0);
        tick();
        check("t4_tmo_set", timeout_err, 1);
        check("t4_no_start", uart_start, 0);
        u_never = 1'b0;
        tick();
        check("t4_regrant", uart_start, 1);
        check("t4_regrant_gid", grant_id, 0);
        drain();
        check("t4_tmo_sticky", timeout_err, 1);

        // asynchronous reset while waiting for the UART to finish
        u_len    = 10;
        bytes[2] = 8'h5A;
        req      = 4'b0100;
        wait_start(40, n);
        check("t5_start", uart_start, 1);
        req = '0;
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        check("t5_ack", ack, 0);
        check("t5_start0", uart_start, 0);
        check("t5_data", uart_data_tx, 0);
        check("t5_gid", grant_id, 0);
        check("t5_tmo", timeout_err, 0);
        uart_busy = 1'b0;
        t_rise    = 0;
        t_fall    = 0;
        @(posedge clk);
        #3;
        reset    = 1'b1;
        bytes[0] = 8'h11;
        bytes[3] = 8'h44;
        req      = 4'b1001;
        tick();
        check("t5_grant", uart_start, 1);
        check("t5_grant_gid", grant_id, 0);
        check("t5_grant_ack", ack, 4'b0001);
        check("t5_grant_data", uart_data_tx, 8'h11);
        drain();

        // req[3] toggled only while the UART is busy: nothing is granted
        u_len = 8;
        req   = 4'b0001;
        wait_start(40, n);
        req = '0;
        repeat (3) tick();
        cnt = 0;
        repeat (4) begin
            req[3] = ~req[3];
            tick();
            if (uart_start || ack != 0) cnt++;
        end
        repeat (12) begin
            tick();
            if (uart_start || ack != 0) cnt++;
        end
        check("t6_no_grant", cnt, 0);
        check("t6_gid", grant_id, 0);

        // randomized traffic against the round-robin predictor
        do_reset();
        exp_last = CORES - 1;
        last_t   = -100;
        nstart   = 0;
        for (int i = 0; i < CORES; i++) bytes[i] = 8'($urandom);
        for (int t = 0; t < 2000; t++) begin
            u_delay = $urandom_range(1, 3);
            u_len   = $urandom_range(1, 6);
            tick();
            if (uart_start) begin
                exp_g = rr_pick(exp_last, req_prev);
                check("r_busy_idle", busy_prev, 0);
                check("r_gid", grant_id, exp_g);
                check("r_ack", ack, (exp_g < 0) ? 0 : (1 << exp_g));
                if (exp_g >= 0) check("r_data", uart_data_tx, bytes_prev[exp_g]);
                check("r_gap", (t - last_t) >= 4, 1);
                exp_last = (exp_g < 0) ? exp_last : exp_g;
                last_t   = t;
                nstart++;
                if (exp_g >= 0) begin
                    bytes[exp_g] = 8'($urandom);
                    if ($urandom_range(0, 1) == 0) req[exp_g] = 1'b0;
                end
            end else begin
                check("r_noack", ack, 0);
                if (!uart_busy && t_rise == 0 && t_fall == 0 && $urandom_range(0, 15) == 0) begin
                    uart_busy = 1'b1;
                    t_fall    = $urandom_range(1, 4);
                end
            end
            for (int i = 0; i < CORES; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            end
        end
        check("r_enough_grants", nstart >= 50, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
